// File: rtl/isa_read_server.sv
// isa_read_server: splits instruction-cache fill requests into DDR read bursts and streams beats back
module isa_read_server #(
    parameter int ISA_WIDTH      = 30,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DDR_DATA_WIDTH = 64,
    parameter int MAX_BURST      = 64,
    parameter int ADDR_STEP      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ISA_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    input  logic [9:0]                isa_read_len,
    output logic [ISA_WIDTH-1:0]      instruction_to_cache,
    output logic                      rd_burst_data_valid,
    output logic [9:0]                rd_cnt_isa,
    output logic                      ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    output logic [9:0]                ddr_rd_len,
    input  logic                      ddr_rd_ack,
    input  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data,
    input  logic                      ddr_rd_data_valid,
    output logic                      isa_busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, DONE, DRAIN} state_t;
    localparam logic [9:0] MB = 10'(MAX_BURST);

    state_t                    state, state_nx;
    logic [DDR_ADDR_WIDTH-1:0] cur_addr;
    logic [9:0]                len_left, burst_left, burst_len;
    logic [ISA_WIDTH-1:0]      d1;
    logic                      start, beat, accept, last;
    logic                      unused_hi;

    assign unused_hi  = ^ddr_rd_data[DDR_DATA_WIDTH-1:ISA_WIDTH];
    assign burst_len  = (len_left > MB) ? MB : len_left;
    assign start      = (state == IDLE) && ISA_read_req && (isa_read_len != 10'd0);
    assign beat       = ddr_rd_data_valid && ((state == STREAM) || (state == DRAIN));
    assign accept     = ddr_rd_data_valid && (state == STREAM) && ISA_read_req;
    assign last       = beat && (burst_left == 10'd1);
    assign ddr_rd_req = (state == ISSUE);
    assign ddr_rd_addr = ddr_rd_req ? cur_addr : '0;
    assign ddr_rd_len  = ddr_rd_req ? burst_len : '0;
    assign isa_busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A burst acked in the same cycle the request drops must still be drained.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE:   state_nx = ddr_rd_ack ? (ISA_read_req ? STREAM : DRAIN)
                                           : (ISA_read_req ? ISSUE : IDLE);
            STREAM:  state_nx = !ISA_read_req ? (last ? IDLE : DRAIN)
                              : last ? ((len_left == 10'd0) ? DONE : ISSUE) : STREAM;
            DONE:    state_nx = ISA_read_req ? DONE : IDLE;
            DRAIN:   state_nx = last ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr             <= '0;
            len_left             <= '0;
            burst_left           <= '0;
            d1                   <= '0;
            rd_burst_data_valid  <= 1'b0;
            instruction_to_cache <= '0;
            rd_cnt_isa           <= '0;
        end else begin
            if (start) begin
                cur_addr <= ISA_read_addr;
                len_left <= isa_read_len;
            end
            if ((state == ISSUE) && ddr_rd_ack) begin
                cur_addr   <= cur_addr + DDR_ADDR_WIDTH'(burst_len) * DDR_ADDR_WIDTH'(ADDR_STEP);
                len_left   <= len_left - burst_len;
                burst_left <= burst_len;
            end
            if (beat) burst_left <= burst_left - 10'd1;
            // Strobe leads data/count by one cycle so a delayed strobe lines up with both.
            rd_burst_data_valid <= accept;
            if (accept) d1 <= ddr_rd_data[ISA_WIDTH-1:0];
            if (start) begin
                rd_cnt_isa <= '0;
            end else if (rd_burst_data_valid) begin
                instruction_to_cache <= d1;
                rd_cnt_isa           <= rd_cnt_isa + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_isa_read_server.sv
// tb_isa_read_server: directed bench with a DDR responder and a strobe/data/count monitor
module tb_isa_read_server;
    logic        clk, rst;
    logic        ISA_read_req;
    logic [27:0] ISA_read_addr;
    logic [9:0]  isa_read_len;
    logic [29:0] instruction_to_cache;
    logic        rd_burst_data_valid;
    logic [9:0]  rd_cnt_isa;
    logic        ddr_rd_req;
    logic [27:0] ddr_rd_addr;
    logic [9:0]  ddr_rd_len;
    logic        ddr_rd_ack;
    logic [63:0] ddr_rd_data;
    logic        ddr_rd_data_valid;
    logic        isa_busy;

    int nchk = 0, nfail = 0;
    int nstr = 0, nreq = 0, base = 0, bidx = 0;
    logic prev_v = 1'b0, prev_req = 1'b0;

    isa_read_server dut (
        .clk(clk), .rst(rst),
        .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr), .isa_read_len(isa_read_len),
        .instruction_to_cache(instruction_to_cache), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_cnt_isa(rd_cnt_isa), .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr),
        .ddr_rd_len(ddr_rd_len), .ddr_rd_ack(ddr_rd_ack), .ddr_rd_data(ddr_rd_data),
        .ddr_rd_data_valid(ddr_rd_data_valid), .isa_busy(isa_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int i);
        return {32'hCAFE_F00D, 32'hEAAA_0000 + 32'(i)};
    endfunction

    function automatic logic [29:0] exp_ins(input int i);
        return 30'h2AAA_0000 + 30'(i);
    endfunction

    // Upper 34 data bits are deliberately non-zero; only the low 30 may reach the cache.
    always @(negedge clk) begin
        if (prev_v) begin
            check("data", instruction_to_cache, exp_ins(nstr - 1 - base));
            check("cnt", rd_cnt_isa, nstr - base);
        end
        prev_v = rd_burst_data_valid;
        if (rd_burst_data_valid) nstr++;
        if (ddr_rd_req && !prev_req) nreq++;
        prev_req = ddr_rd_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [27:0] a, input logic [9:0] l);
        base = nstr;
        bidx = 0;
        ISA_read_addr = a;
        isa_read_len  = l;
        ISA_read_req  = 1'b1;
        step();
    endtask

    task automatic serve(input logic [27:0] ea, input int el, input int gap, input int drop_at, input int nb);
        int w = 0;
        while (!ddr_rd_req && w < 50) begin
            step();
            w++;
        end
        check("req_seen", ddr_rd_req, 1);
        check("burst_addr", ddr_rd_addr, ea);
        check("burst_len", ddr_rd_len, el);
        ddr_rd_ack = 1'b1;
        step();
        ddr_rd_ack = 1'b0;
        check("req_drop", ddr_rd_req, 0);
        for (int k = 0; k < nb; k++) begin
            if (k == drop_at) ISA_read_req = 1'b0;
            ddr_rd_data       = mk(bidx);
            ddr_rd_data_valid = 1'b1;
            step();
            ddr_rd_data_valid = 1'b0;
            for (int j = 0; j < gap; j++) begin
                step();
                if (j > 0) begin
                    check("hold_cnt", rd_cnt_isa, bidx + 1);
                    check("hold_ins", instruction_to_cache, exp_ins(bidx));
                end
            end
            bidx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        rst = 1'b1;
        ISA_read_req = 1'b0;
        ISA_read_addr = '0;
        isa_read_len = '0;
        ddr_rd_ack = 1'b0;
        ddr_rd_data = '0;
        ddr_rd_data_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_strobe", rd_burst_data_valid, 0);
        check("rst_cnt", rd_cnt_isa, 0);
        check("rst_ins", instruction_to_cache, 0);
        check("rst_req", ddr_rd_req, 0);
        check("rst_busy", isa_busy, 0);

        // 1: single short burst, back-to-back beats
        r0 = nreq;
        start(28'h10, 10'd4);
        serve(28'h10, 4, 0, -1, 4);
        repeat (3) step();
        check("t1_strobes", nstr - base, 4);
        check("t1_cnt", rd_cnt_isa, 4);
        check("t1_nreq", nreq - r0, 1);
        check("t1_done_busy", isa_busy, 1);
        ISA_read_req = 1'b0;
        step();
        check("t1_idle", isa_busy, 0);

        // 2: split into two max bursts
        r0 = nreq;
        start(28'h100, 10'd128);
        serve(28'h100, 64, 0, -1, 64);
        serve(28'h300, 64, 0, -1, 64);
        repeat (4) step();
        check("t2_strobes", nstr - base, 128);
        check("t2_cnt", rd_cnt_isa, 128);
        check("t2_nreq", nreq - r0, 2);
        check("t2_done_busy", isa_busy, 1);
        ISA_read_req = 1'b0;
        step();
        check("t2_idle", isa_busy, 0);

        // 3: gaps between beats
        start(28'h40, 10'd8);
        serve(28'h40, 8, 3, -1, 8);
        step();
        check("t3_strobes", nstr - base, 8);
        check("t3_cnt", rd_cnt_isa, 8);
        ISA_read_req = 1'b0;
        step();

        // 4: request dropped after ten beats, rest drained
        r0 = nreq;
        start(28'h0, 10'd64);
        serve(28'h0, 64, 0, 10, 64);
        repeat (4) step();
        check("t4_strobes", nstr - base, 10);
        check("t4_cnt", rd_cnt_isa, 10);
        check("t4_nreq", nreq - r0, 1);
        check("t4_idle", isa_busy, 0);

        // 6: zero-length request ignored
        r0 = nreq;
        ISA_read_addr = 28'h55;
        isa_read_len = 10'd0;
        ISA_read_req = 1'b1;
        repeat (5) begin
            step();
            check("t6_busy", isa_busy, 0);
        end
        check("t6_nreq", nreq - r0, 0);
        ISA_read_req = 1'b0;
        step();

        // 5: asynchronous reset mid-stream
        start(28'h80, 10'd8);
        serve(28'h80, 8, 0, -1, 3);
        repeat (2) step();
        check("t5_cnt_pre", rd_cnt_isa, 3);
        rst = 1'b1;
        ISA_read_req = 1'b0;
        #1;
        check("t5_strobe", rd_burst_data_valid, 0);
        check("t5_cnt", rd_cnt_isa, 0);
        check("t5_ins", instruction_to_cache, 0);
        check("t5_req", ddr_rd_req, 0);
        check("t5_addr", ddr_rd_addr, 0);
        check("t5_len", ddr_rd_len, 0);
        check("t5_busy", isa_busy, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ddr_rd_data = mk(50 + k);
            ddr_rd_data_valid = 1'b1;
            step();
        end
        ddr_rd_data_valid = 1'b0;
        repeat (2) step();
        check("t5_late_strobes", nstr - base, 3);
        check("t5_late_busy", isa_busy, 0);

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule
